axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Synthesizable AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write or read transactions and returns the completion response. It is the master-side counterpart of the `dataplane_top` AXI4-Lite slave port. It lets on-chip logic, such as a sequencer or a UART debug bridge, program the dataplane registers without the PS. One transaction is outstanding at a time; AW and W are issued together and may complete in either order.

## Interface
Parameters:
- `ADDR_W`, 32: AXI address width.
- `DATA_W`, 32: AXI data width. Only 32 is supported.
- `PROT`, 3'b000: constant value driven on `AWPROT`/`ARPROT`.
- `TIMEOUT_CYCLES`, 1024: watchdog limit. Used only with `AXI_LITE_MASTER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  byte address. Bits [1:0] are ignored.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_wstrb`  in  DATA_W/8  write byte strobes.
- `rsp_valid`  out  1  completion available.
- `rsp_ready`  in  1  completion consumed.
- `rsp_write`  out  1  echoes `cmd_write` of the completed command.
- `rsp_rdata`  out  DATA_W  read data. Zero for writes.
- `rsp_resp`  out  2  BRESP or RRESP of the completed transaction.
- AXI write address: `AWADDR` out ADDR_W, `AWPROT` out 3, `AWVALID` out 1, `AWREADY` in 1.
- AXI write data: `WDATA` out DATA_W, `WSTRB` out DATA_W/8, `WVALID` out 1, `WREADY` in 1.
- AXI write response: `BVALID` in 1, `BREADY` out 1, `BRESP` in 2.
- AXI read address: `ARADDR` out ADDR_W, `ARPROT` out 3, `ARVALID` out 1, `ARREADY` in 1.
- AXI read data: `RVALID` in 1, `RREADY` out 1, `RDATA` in DATA_W, `RRESP` in 2.
- `timeout_err`  out  1  sticky watchdog flag. Present only with the macro defined.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, register address, data and strobes. Address is stored as `{cmd_addr[ADDR_W-1:2],2'b00}`.
  - Next state is WR_REQ for a write, RD_REQ for a read.
- **WR_REQ**
  - `AWVALID` and `WVALID` are both high on entry.
  - Each valid drops independently on its own handshake.
  - Address, data and strobes stay stable while the corresponding valid is high.
  - When both handshakes are done, including in the same cycle, go to WR_RESP.
- **WR_RESP**
  - `BREADY`=1.
  - On `BVALID`, capture `BRESP` and set `rsp_rdata`=0. Go to RSP.
- **RD_REQ**
  - `ARVALID`=1 until `ARREADY`, then go to RD_DATA.
- **RD_DATA**
  - `RREADY`=1.
  - On `RVALID`, capture `RDATA`/`RRESP`. Go to RSP.
- **RSP**
  - `rsp_valid`=1 with stable payload until `rsp_ready`, then go to IDLE.
  - `cmd_ready` is 0 in every state except IDLE. Back-to-back commands are therefore separated by at least one IDLE cycle.
- All AXI outputs and response outputs are registered.
- `BREADY`/`RREADY` are never high outside WR_RESP/RD_DATA. A `BVALID`/`RVALID` arriving in another state is not acknowledged.

## Timing
- Reset state: IDLE.
  - All valid and ready outputs are 0, except `cmd_ready`=1.
  - `AWADDR`, `WDATA`, `WSTRB`, `ARADDR`, `rsp_rdata`, `rsp_resp`, `rsp_write` are 0.
  - `AWPROT`/`ARPROT` are `PROT`.
- Minimum write latency with a zero-wait slave:
  - cycle 0: command accepted.
  - cycle 1: AW and W handshake.
  - cycle 2: `BREADY` high, B handshake.
  - cycle 3: `rsp_valid` high.
- Minimum read latency is also 3 cycles from command acceptance to `rsp_valid`.
- Slave stalls add cycles 1:1. There is no upper bound without the watchdog.
- Reset asserted mid-transaction returns to IDLE immediately and drops all valids. The slave is reset together with this block.

## Configuration
- `AXI_LITE_MASTER_TIMEOUT_EN` defined:
  - A counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA, and clears on entry to RSP or IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`, `timeout_err` sets and stays set until `rst`.
  - The transaction is not aborted; valids are held per protocol.
- Not defined: no counter and no `timeout_err` port.

## Test plan
- Write 0xDEADBEEF, wstrb 4'hF, to 0x10 on a zero-wait slave -> AWADDR=0x10 and WDATA=0xDEADBEEF in the same cycle; `rsp_valid` 3 cycles after acceptance; `rsp_resp`=0, `rsp_write`=1.
- Write with `AWREADY` delayed 4 cycles and `WREADY` immediate -> `WVALID` drops after 1 cycle, `AWVALID` held 5 cycles, exactly one B handshake.
- Read 0x04 with slave returning 0x12345678 after `RVALID` delay of 2 -> `rsp_rdata`=0x12345678, `rsp_write`=0, `cmd_ready`=0 until `rsp_ready`.
- `cmd_addr`=0x13 -> ARADDR=0x10. SLVERR (2'b10) on RRESP -> `rsp_resp`=2'b10.
- `rsp_ready` held low for 10 cycles -> payload stable, `cmd_ready`=0. `rst` pulsed during WR_REQ -> next cycle `AWVALID`=`WVALID`=0, `cmd_ready`=1.
- With the macro and `TIMEOUT_CYCLES`=16, slave never asserts `ARREADY` -> `timeout_err`=1 after 16 cycles in RD_REQ, `ARVALID` still 1.

Source files
------------

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between axi_lite_cmd_master and an AXI4-Lite slave.
// Master drives AW/W/AR channels and the B/R ready signals.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic                BVALID;
  logic                BREADY;
  logic [1:0]          BRESP;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic                RVALID;
  logic                RREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BVALID, BRESP, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BVALID, BRESP, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one completion out.
// Optional watchdog (sticky timeout_err) enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int         ADDR_W         = 32,
  parameter int         DATA_W         = 32,
  parameter logic [2:0] PROT           = 3'b000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  axi_lite_cmd_master_if.master axi
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  , output logic              timeout_err
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi_lite_cmd_master: DATA_W must be 32 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]          state_r;
  logic                cmd_ready_r;
  logic                awvalid_r;
  logic                wvalid_r;
  logic                bready_r;
  logic                arvalid_r;
  logic                rready_r;
  logic                rsp_valid_r;
  logic                rsp_write_r;
  logic [ADDR_W-1:0]   awaddr_r;
  logic [ADDR_W-1:0]   araddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic [1:0]          rsp_resp_r;
  logic [ADDR_W-1:0]   addr_aligned_s;
  logic                aw_done_s;
  logic                w_done_s;

  // Masking keeps every address bit in use; bits [1:0] are forced to zero.
  assign addr_aligned_s = cmd_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  // A channel counts as done once its valid has already dropped or is handshaking now.
  assign aw_done_s      = !awvalid_r || axi.AWREADY;
  assign w_done_s       = !wvalid_r  || axi.WREADY;

  // Transaction sequencer: owns every registered AXI and response output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      awaddr_r    <= {ADDR_W{1'b0}};
      araddr_r    <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      wstrb_r     <= {(DATA_W/8){1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_resp_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_r <= 1'b0;
            if (cmd_write) begin
              state_r   <= ST_WR_REQ;
              awaddr_r  <= addr_aligned_s;
              wdata_r   <= cmd_wdata;
              wstrb_r   <= cmd_wstrb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= ST_RD_REQ;
              araddr_r  <= addr_aligned_s;
              arvalid_r <= 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          if (awvalid_r && axi.AWREADY) awvalid_r <= 1'b0;
          if (wvalid_r && axi.WREADY)   wvalid_r  <= 1'b0;
          if (aw_done_s && w_done_s) begin
            state_r  <= ST_WR_RESP;
            bready_r <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (axi.BVALID) begin
            state_r     <= ST_RSP;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= 1'b1;
            rsp_resp_r  <= axi.BRESP;
            rsp_rdata_r <= {DATA_W{1'b0}};
          end
        end
        ST_RD_REQ: begin
          if (axi.ARREADY) begin
            state_r   <= ST_RD_DATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (axi.RVALID) begin
            state_r     <= ST_RSP;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= 1'b0;
            rsp_resp_r  <= axi.RRESP;
            rsp_rdata_r <= axi.RDATA;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_write   = rsp_write_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_resp    = rsp_resp_r;
  assign axi.AWADDR  = awaddr_r;
  assign axi.AWPROT  = PROT;
  assign axi.AWVALID = awvalid_r;
  assign axi.WDATA   = wdata_r;
  assign axi.WSTRB   = wstrb_r;
  assign axi.WVALID  = wvalid_r;
  assign axi.BREADY  = bready_r;
  assign axi.ARADDR  = araddr_r;
  assign axi.ARPROT  = PROT;
  assign axi.ARVALID = arvalid_r;
  assign axi.RREADY  = rready_r;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_r;
  logic             timeout_err_r;
  logic             busy_s;

  assign busy_s = (state_r == ST_WR_REQ) || (state_r == ST_WR_RESP) ||
                  (state_r == ST_RD_REQ) || (state_r == ST_RD_DATA);

  // Watchdog: counts bus-wait cycles, saturates, and latches the error until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (busy_s) begin
      if (wdog_cnt_r != CNT_W'(TIMEOUT_CYCLES)) wdog_cnt_r <= wdog_cnt_r + 1'b1;
      if (wdog_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_err_r <= 1'b1;
    end else begin
      wdog_cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign timeout_err = timeout_err_r;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized self-checking bench for axi_lite_cmd_master with a delay-programmable AXI slave
// and a word-array reference model of register contents and completion latency.
module tb_axi_lite_cmd_master;
  localparam int         ADDR_W = 32;
  localparam int         DATA_W = 32;
  localparam logic [2:0] PROT   = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic        timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  axi_lite_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_lite_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT(PROT), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(axi)
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Slave configuration, set between transactions by the test tasks.
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;

  // Slave state and cumulative observation counters.
  logic [31:0] slv_mem [16];
  logic [31:0] model_mem [16];
  int          cyc = 0;
  logic        aw_got, w_got, b_pend, r_pend, aw_first_v, w_first_v;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [31:0] s_awaddr, s_wdata, s_araddr, aw_first;
  logic [35:0] w_first;
  logic [3:0]  s_wstrb;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_n = 0, r_hs_n = 0;
  int          aw_hi = 0, w_hi = 0, unstable_n = 0;

  // Slave outputs change on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    axi.AWREADY = axi.AWVALID && (aw_wait >= aw_dly);
    axi.WREADY  = axi.WVALID && (w_wait >= w_dly);
    axi.BVALID  = b_pend && (b_wait >= b_dly);
    axi.BRESP   = axi.BVALID ? s_bresp : 2'b11;
    axi.ARREADY = axi.ARVALID && (ar_wait >= ar_dly);
    axi.RVALID  = r_pend && (r_wait >= r_dly);
    axi.RDATA   = axi.RVALID ? slv_mem[s_araddr[5:2]] : 32'hA5A5_A5A5;
    axi.RRESP   = axi.RVALID ? s_rresp : 2'b11;
  end

  // Slave handshake bookkeeping on the rising edge; reset along with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      aw_first_v = 1'b0; w_first_v = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      s_araddr = 32'h0;
      for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0;
    end else begin
      cyc++;
      if (axi.BVALID && axi.BREADY) begin b_pend = 1'b0; b_hs_n++; end
      else if (b_pend) b_wait++;
      if (axi.RVALID && axi.RREADY) begin r_pend = 1'b0; r_hs_n++; end
      else if (r_pend) r_wait++;
      if (axi.AWVALID) begin
        aw_hi++;
        if (aw_first_v && axi.AWADDR !== aw_first) unstable_n++;
        aw_first = axi.AWADDR; aw_first_v = 1'b1;
        if (axi.AWREADY) begin
          aw_got = 1'b1; s_awaddr = axi.AWADDR; aw_hs_cyc = cyc; aw_wait = 0; aw_first_v = 1'b0;
        end else aw_wait++;
      end
      if (axi.WVALID) begin
        w_hi++;
        if (w_first_v && {axi.WSTRB, axi.WDATA} !== w_first) unstable_n++;
        w_first = {axi.WSTRB, axi.WDATA}; w_first_v = 1'b1;
        if (axi.WREADY) begin
          w_got = 1'b1; s_wdata = axi.WDATA; s_wstrb = axi.WSTRB; w_hs_cyc = cyc; w_wait = 0; w_first_v = 1'b0;
        end else w_wait++;
      end
      if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_wait = 0;
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) slv_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
      end
      if (axi.ARVALID) begin
        if (axi.ARREADY) begin
          s_araddr = axi.ARADDR; r_pend = 1'b1; r_wait = 0; ar_wait = 0;
        end else ar_wait++;
      end
    end
  end

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    for (int b = 0; b < 4; b++)
      if (ws[b]) model_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Drives one command and collects the completion; the callers do the comparisons.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int hold,
                         output int lat, output logic o_write, output logic [31:0] o_rdata,
                         output logic [1:0] o_resp, output bit stable, output bit busy_low,
                         output bit done);
    int guard;
    lat = 0; stable = 1'b1; busy_low = 1'b1; done = 1'b0;
    o_write = 1'b0; o_rdata = 32'h0; o_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom(); cmd_wdata = $urandom();
    cmd_wstrb = 4'($urandom());
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) busy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) return;
    if (cmd_ready) busy_low = 1'b0;
    o_write = rsp_write; o_rdata = rsp_rdata; o_resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_write !== o_write || rsp_rdata !== o_rdata || rsp_resp !== o_resp) stable = 1'b0;
      if (cmd_ready) busy_low = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    done = 1'b1;
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic test_reset;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids: got %b want 000000",
                         {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, rsp_valid}); end
    checks++; if ({axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR} !== 100'h0) begin
      errors++; $display("FAIL reset_axi_payload: got %h want 0", {axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR}); end
    checks++; if ({rsp_rdata, rsp_resp, rsp_write} !== 35'h0) begin
      errors++; $display("FAIL reset_rsp_payload: got %h want 0", {rsp_rdata, rsp_resp, rsp_write}); end
    checks++; if (axi.AWPROT !== PROT || axi.ARPROT !== PROT) begin
      errors++; $display("FAIL reset_prot: got %b/%b want %b", axi.AWPROT, axi.ARPROT, PROT); end
  endtask

  task automatic test_write_basic;
    int lat; logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    set_delays(0, 0, 0, 0, 0); s_bresp = 2'b00;
    run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, lat, ow, ord, ors, st, bl, dn);
    model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL wr_basic_done: got %b want 1", dn); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_basic_latency: got %0d want 3", lat); end
    checks++; if ({ow, ors, ord} !== {1'b1, 2'b00, 32'h0}) begin
      errors++; $display("FAIL wr_basic_rsp: got w=%b r=%b d=%h want w=1 r=00 d=0", ow, ors, ord); end
    checks++; if (s_awaddr !== 32'h10 || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_basic_bus: got a=%h d=%h s=%h want 10/deadbeef/f", s_awaddr, s_wdata, s_wstrb); end
    checks++; if (aw_hs_cyc != w_hs_cyc) begin
      errors++; $display("FAIL wr_basic_same_cycle: got aw@%0d w@%0d want equal", aw_hs_cyc, w_hs_cyc); end
  endtask

  task automatic test_write_stall;
    int lat, aw0, w0, b0, u0; logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    aw0 = aw_hi; w0 = w_hi; b0 = b_hs_n; u0 = unstable_n;
    set_delays(4, 0, 0, 0, 0); s_bresp = 2'b01;
    run_cmd(1'b1, 32'h20, 32'hCAFE_0123, 4'h5, 0, lat, ow, ord, ors, st, bl, dn);
    model_write(32'h20, 32'hCAFE_0123, 4'h5);
    checks++; if (aw_hi - aw0 != 5) begin errors++; $display("FAIL wr_stall_awvalid_cycles: got %0d want 5", aw_hi - aw0); end
    checks++; if (w_hi - w0 != 1) begin errors++; $display("FAIL wr_stall_wvalid_cycles: got %0d want 1", w_hi - w0); end
    checks++; if (b_hs_n - b0 != 1) begin errors++; $display("FAIL wr_stall_b_handshakes: got %0d want 1", b_hs_n - b0); end
    checks++; if (lat != 7 || ors !== 2'b01) begin errors++; $display("FAIL wr_stall_rsp: got lat=%0d resp=%b want 7/01", lat, ors); end
    checks++; if (unstable_n != u0) begin errors++; $display("FAIL wr_stall_stable: got %0d changes want 0", unstable_n - u0); end
  endtask

  task automatic test_read;
    int lat; logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    set_delays(0, 0, 0, 0, 0); s_bresp = 2'b00;
    run_cmd(1'b1, 32'h04, 32'h1234_5678, 4'hF, 0, lat, ow, ord, ors, st, bl, dn);
    model_write(32'h04, 32'h1234_5678, 4'hF);
    set_delays(0, 0, 0, 0, 2); s_rresp = 2'b00;
    run_cmd(1'b0, 32'h04, 32'h0, 4'h0, 3, lat, ow, ord, ors, st, bl, dn);
    checks++; if (ord !== 32'h1234_5678 || ow !== 1'b0) begin
      errors++; $display("FAIL rd_data: got d=%h w=%b want 12345678/0", ord, ow); end
    checks++; if (lat != 5) begin errors++; $display("FAIL rd_latency: got %0d want 5", lat); end
    checks++; if (bl !== 1'b1) begin errors++; $display("FAIL rd_cmd_ready_busy: got %b want 1", bl); end
  endtask

  task automatic test_align_slverr;
    int lat; logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    set_delays(0, 0, 0, 1, 0); s_rresp = 2'b10;
    run_cmd(1'b0, 32'h13, 32'h0, 4'h0, 0, lat, ow, ord, ors, st, bl, dn);
    checks++; if (s_araddr !== 32'h10) begin errors++; $display("FAIL rd_align_araddr: got %h want 10", s_araddr); end
    checks++; if (ors !== 2'b10 || ord !== model_mem[4]) begin
      errors++; $display("FAIL rd_slverr: got r=%b d=%h want 10/%h", ors, ord, model_mem[4]); end
  endtask

  task automatic test_rsp_hold;
    int lat; logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    set_delays(1, 2, 1, 0, 0); s_bresp = 2'b11;
    run_cmd(1'b1, 32'h3C, 32'h0F0F_AA55, 4'h9, 10, lat, ow, ord, ors, st, bl, dn);
    model_write(32'h3C, 32'h0F0F_AA55, 4'h9);
    checks++; if (st !== 1'b1 || bl !== 1'b1 || dn !== 1'b1) begin
      errors++; $display("FAIL rsp_hold: got stable=%b busy=%b done=%b want 1/1/1", st, bl, dn); end
    checks++; if (ors !== 2'b11 || lat != 6) begin errors++; $display("FAIL rsp_hold_rsp: got r=%b lat=%0d want 11/6", ors, lat); end
  endtask

  task automatic test_reset_mid;
    set_delays(8, 8, 0, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h08; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({axi.AWVALID, axi.WVALID, cmd_ready} !== 3'b110) begin
      errors++; $display("FAIL rstmid_pre: got %b want 110", {axi.AWVALID, axi.WVALID, cmd_ready}); end
    rst = 1'b1; #1;
    checks++; if ({axi.AWVALID, axi.WVALID, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL rstmid_async: got %b want 001", {axi.AWVALID, axi.WVALID, cmd_ready}); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    @(posedge clk); #1;
    checks++; if ({axi.AWVALID, axi.WVALID, cmd_ready, rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL rstmid_after: got %b want 0010", {axi.AWVALID, axi.WVALID, cmd_ready, rsp_valid}); end
  endtask

  task automatic test_random;
    logic wr; logic [31:0] addr, wd, exp_rd; logic [3:0] ws; logic [1:0] exp_rs;
    int hold, lat, exp_lat, b0, r0;
    logic ow; logic [31:0] ord; logic [1:0] ors; bit st, bl, dn;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1)); addr = 32'($urandom_range(0, 63));
      wd = $urandom(); ws = 4'($urandom_range(0, 15)); hold = $urandom_range(0, 2);
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      s_bresp = 2'($urandom_range(0, 3)); s_rresp = 2'($urandom_range(0, 3));
      exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      exp_rd  = wr ? 32'h0 : model_mem[addr[5:2]];
      exp_rs  = wr ? s_bresp : s_rresp;
      b0 = b_hs_n; r0 = r_hs_n;
      run_cmd(wr, addr, wd, ws, hold, lat, ow, ord, ors, st, bl, dn);
      if (wr) model_write(addr, wd, ws);
      checks++; if (dn !== 1'b1 || lat != exp_lat) begin
        errors++; $display("FAIL rand_latency[%0d]: got done=%b lat=%0d want 1/%0d", n, dn, lat, exp_lat); end
      checks++; if (ow !== wr || ors !== exp_rs || ord !== exp_rd) begin
        errors++; $display("FAIL rand_rsp[%0d]: got w=%b r=%b d=%h want %b/%b/%h", n, ow, ors, ord, wr, exp_rs, exp_rd); end
      checks++; if ((b_hs_n - b0) != (wr ? 1 : 0) || (r_hs_n - r0) != (wr ? 0 : 1)) begin
        errors++; $display("FAIL rand_handshakes[%0d]: got b=%0d r=%0d", n, b_hs_n - b0, r_hs_n - r0); end
      if (wr) begin
        checks++; if (s_awaddr !== {addr[31:2], 2'b00} || s_wdata !== wd || s_wstrb !== ws) begin
          errors++; $display("FAIL rand_wbus[%0d]: got a=%h d=%h s=%h want %h/%h/%h",
                             n, s_awaddr, s_wdata, s_wstrb, {addr[31:2], 2'b00}, wd, ws); end
      end
    end
  endtask

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    set_delays(0, 0, 0, 1000, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    @(posedge clk); #1;
    checks++; if (timeout_err !== 1'b1 || axi.ARVALID !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got err=%b arvalid=%b want 1/1", timeout_err, axi.ARVALID); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_align_slverr();
    test_rsp_hold();
    test_reset_mid();
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
